program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Writes a program into the 32x10 instruction memory that the control unit fetches from.
//  Receives a byte stream on a valid/ready interface and packs it into 10-bit instruction words.
//  Holds the processor in reset until a complete image has passed its checksum.
// PARAMETERS
//  ADDR_W  5   instruction-memory address width
//  INST_W  10  instruction width (opcode[9:5], operand[4:0])
//  DEPTH   32  maximum words per image (2**ADDR_W)
// PORTS
//  clock         in   1       single clock; all logic on rising edge
//  reset         in   1       synchronous, active-high
//  start         in   1       1-cycle pulse; begins a load from IDLE, DONE or ERROR
//  in_valid      in   1       byte on in_data is valid
//  in_data       in   8       stream byte
//  in_ready      out  1       loader accepts the byte this cycle (transfer = in_valid & in_ready)
//  mem_address   out  ADDR_W  instruction-memory write address
//  mem_data      out  INST_W  instruction-memory write data
//  mem_wren      out  1       1-cycle write strobe
//  cpu_hold      out  1       drives processor reset; high unless an image loaded OK
//  busy          out  1       load in progress
//  done          out  1       last load succeeded (level)
//  err_code      out  2       00 none, 01 bad length, 10 bad high byte, 11 checksum mismatch
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0, mem_wren=0, mem_address=0, mem_data=0, cpu_hold=1,
//   busy=0, done=0, err_code=00, count=0, xor_acc=0.
//  Frame format: LEN, {HI,LO} x LEN, CHK. LEN is 1..32. HI[7:2] must be 0.
//   word = {HI[1:0],LO}. CHK = XOR of LEN and every HI and LO byte.
//  FSM states:
//   IDLE  : in_ready=0. On start -> HEADER, busy=1, done=0, err_code=00, cpu_hold=1, xor_acc=0.
//   HEADER: in_ready=1. On transfer, xor_acc^=byte.
//           LEN==0 or LEN>32 -> ERROR(01). Otherwise count=LEN and address=0 -> HI.
//   HI    : in_ready=1. On transfer: byte[7:2]!=0 -> ERROR(10). Otherwise latch byte[1:0], xor -> LO.
//   LO    : in_ready=1. On transfer: latch, xor -> WRITE.
//   WRITE : in_ready=0. mem_wren=1 for exactly this cycle with the current address and word.
//           Then address++ and count--. count reaching 0 -> CHECK, else -> HI.
//   CHECK : in_ready=1. On transfer: byte==xor_acc -> DONE, else ERROR(11).
//   DONE  : busy=0, done=1, cpu_hold=0. start -> HEADER (cpu_hold returns to 1).
//   ERROR : busy=0, done=0, cpu_hold=1, err_code held. start -> HEADER.
//  Latency: one mem_wren per word, exactly 1 cycle after the LO transfer.
//   cpu_hold falls 1 cycle after the CHK transfer.
//  in_valid low: state holds indefinitely; there is no timeout.
//  Bytes presented while in_ready=0 are not consumed.
//  start while busy: ignored.
//  mem_address never wraps: LEN<=32 guarantees the last write goes to address LEN-1.
//  Words already written before an ERROR stay in memory; cpu_hold=1 keeps them from executing.
//  Reset mid-load: immediate return to the reset state with no write in that cycle;
//   cpu_hold stays 1.
// STRUCTURE
//  Shared package: state encoding (8 states, 3 bits), ERR_* codes, INST_W/ADDR_W constants
//   shared with the control unit.
//  Single module, no sub-module. The XOR accumulator and counters are inline.
// TESTING
//  1. LEN=03, words 0x0A5,0x3FF,0x001, correct CHK -> writes @0=0x0A5, @1=0x3FF, @2=0x001;
//     done=1; cpu_hold=0.
//  2. LEN=00 -> err_code=01, no mem_wren. Same for LEN=0x21.
//  3. LEN=02, first HI=0x04 -> err_code=10, zero writes, cpu_hold=1.
//  4. LEN=02, valid words, CHK off by 0x01 -> 2 writes, then err_code=11, cpu_hold=1.
//  5. LEN=32 with random in_valid gaps -> 32 writes at @0..@31, no write at @0 after @31, done=1.
//  6. reset during the 2nd LO byte -> no further writes; IDLE outputs; a new start then LEN=01
//     load succeeds.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the control unit it feeds.
package program_loader_pkg;

    localparam int ADDR_W = 5;
    localparam int INST_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_LEN  = 2'b01,
        ERR_HIGH = 2'b10,
        ERR_CHK  = 2'b11
    } err_t;

    // A frame carries 1..DEPTH words; anything else cannot fit the memory.
    function automatic logic len_ok(input logic [7:0] len);
        return (len != 8'd0) && (len <= 8'(DEPTH));
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, instruction-memory write port out.
interface program_loader_if;
    import program_loader_pkg::*;

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [INST_W-1:0] mem_data;
    logic              mem_wren;

    // Stream source / memory sink side
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_address, mem_data, mem_wren
    );

    // Loader side
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_address, mem_data, mem_wren
    );

endinterface

// File: rtl/program_loader.sv
// Packs a checksummed byte stream into 10-bit words, writes them to the
// instruction memory and releases the processor only after a clean image.
module program_loader
    import program_loader_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    program_loader_if.slave  bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err_code
);

    state_t            state, state_nx;
    err_t              err, err_nx;
    logic [5:0]        count, count_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [1:0]        hi, hi_nx;
    logic [7:0]        lo, lo_nx;
    logic [7:0]        xor_acc, xor_nx;
    logic              ready;
    logic              xfer;

    // Reset gates the handshake and the write strobe so nothing moves in the reset cycle.
    assign ready = !reset && (state inside {S_HEADER, S_HI, S_LO, S_CHECK});
    assign xfer  = bus.in_valid & ready;

    assign bus.in_ready    = ready;
    assign bus.mem_wren    = !reset && (state == S_WRITE);
    assign bus.mem_address = addr;
    assign bus.mem_data    = {hi, lo};

    assign busy     = state inside {S_HEADER, S_HI, S_LO, S_WRITE, S_CHECK};
    assign done     = (state == S_DONE);
    assign cpu_hold = !done;
    assign err_code = err;

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            err     <= ERR_NONE;
            count   <= '0;
            addr    <= '0;
            hi      <= '0;
            lo      <= '0;
            xor_acc <= '0;
        end else begin
            state   <= state_nx;
            err     <= err_nx;
            count   <= count_nx;
            addr    <= addr_nx;
            hi      <= hi_nx;
            lo      <= lo_nx;
            xor_acc <= xor_nx;
        end
    end

    // Next-state and datapath updates for the frame parser.
    always_comb begin
        state_nx = state;
        err_nx   = err;
        count_nx = count;
        addr_nx  = addr;
        hi_nx    = hi;
        lo_nx    = lo;
        xor_nx   = xor_acc;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nx = S_HEADER;
                    err_nx   = ERR_NONE;
                    xor_nx   = '0;
                end
            end
            S_HEADER: begin
                if (xfer) begin
                    xor_nx = xor_acc ^ bus.in_data;
                    if (!len_ok(bus.in_data)) begin
                        state_nx = S_ERROR;
                        err_nx   = ERR_LEN;
                    end else begin
                        count_nx = bus.in_data[5:0];
                        addr_nx  = '0;
                        state_nx = S_HI;
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    if (bus.in_data[7:2] != 6'd0) begin
                        state_nx = S_ERROR;
                        err_nx   = ERR_HIGH;
                    end else begin
                        hi_nx    = bus.in_data[1:0];
                        xor_nx   = xor_acc ^ bus.in_data;
                        state_nx = S_LO;
                    end
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_nx    = bus.in_data;
                    xor_nx   = xor_acc ^ bus.in_data;
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address may wrap to 0 after word 31, but no further write follows.
                addr_nx  = addr + 1'b1;
                count_nx = count - 1'b1;
                state_nx = (count == 6'd1) ? S_CHECK : S_HI;
            end
            S_CHECK: begin
                if (xfer) begin
                    if (bus.in_data == xor_acc) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_ERROR;
                        err_nx   = ERR_CHK;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames against a frame-level reference model.
module tb_program_loader;
    import program_loader_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic [1:0] err_code;

    program_loader_if bus();

    program_loader dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err_code (err_code)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Every memory write observed, as {address, word}.
    logic [14:0] wr_q[$];
    always @(posedge clock) if (bus.mem_wren === 1'b1) wr_q.push_back({bus.mem_address, bus.mem_data});

    logic [7:0] frame[$];
    logic [9:0] words[$];
    logic [9:0] exp_words[$];
    int         exp_consumed;
    logic [1:0] exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the frame byte list and decide outcome, words written, bytes consumed.
    task automatic model();
        int         len;
        logic [7:0] x;
        logic [7:0] h;
        logic [7:0] l;
        exp_words.delete();
        len = int'(frame[0]);
        x   = frame[0];
        if (len == 0 || len > DEPTH) begin
            exp_err      = 2'b01;
            exp_consumed = 1;
            return;
        end
        for (int i = 0; i < len; i++) begin
            h = frame[1 + 2 * i];
            l = frame[2 + 2 * i];
            if (h > 8'd3) begin
                exp_err      = 2'b10;
                exp_consumed = 2 + 2 * i;
                return;
            end
            exp_words.push_back({h[1:0], l});
            x = x ^ h ^ l;
        end
        exp_consumed = 2 * len + 2;
        exp_err      = (frame[2 * len + 1] == x) ? 2'b00 : 2'b11;
    endtask

    // Serialize 'words' into a frame; optional bad HI at bad_idx and checksum offset.
    task automatic build(input int len, input logic [7:0] chk_delta, input int bad_idx, input logic [7:0] bad_hi);
        logic [7:0] x;
        logic [7:0] h;
        frame.delete();
        frame.push_back(8'(len));
        if (len == 0 || len > DEPTH) return;
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
            h = (i == bad_idx) ? bad_hi : {6'b0, words[i][9:8]};
            frame.push_back(h);
            frame.push_back(words[i][7:0]);
            x = x ^ h ^ words[i][7:0];
        end
        frame.push_back(x ^ chk_delta);
    endtask

    task automatic rand_words(input int len);
        words.delete();
        for (int i = 0; i < len; i++) words.push_back(10'($urandom));
    endtask

    // Offer one byte starting on a falling edge; return on the falling edge after it is taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait", 32'(n < 40), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_frame(input bit gaps, input bit poke_start);
        model();
        wr_q.delete();
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        check("hold_after_start", 32'(cpu_hold), 32'd1);
        check("err_after_start", 32'(err_code), 32'd0);
        for (int b = 0; b < exp_consumed; b++) begin
            // A start while busy must change nothing.
            if (poke_start && b == 1) pulse_start();
            send_byte(frame[b], gaps);
            if (b >= 2 && b % 2 == 0) begin
                check("wren_after_lo", 32'(bus.mem_wren), 32'd1);
                check("wr_addr", 32'(bus.mem_address), 32'((b - 2) / 2));
                check("wr_data", 32'(bus.mem_data), 32'(exp_words[(b - 2) / 2]));
            end
        end
        check("busy_end", 32'(busy), 32'd0);
        check("done_end", 32'(done), 32'(exp_err == 2'b00));
        check("hold_end", 32'(cpu_hold), 32'(exp_err != 2'b00));
        check("err_end", 32'(err_code), 32'(exp_err));
        repeat (3) @(negedge clock);
        check("wr_count", 32'(wr_q.size()), 32'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < wr_q.size(); i++)
            check("wr_log", 32'(wr_q[i]), 32'({5'(i), exp_words[i]}));
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
        check("rst_mem_address", 32'(bus.mem_address), 32'd0);
        check("rst_mem_data", 32'(bus.mem_data), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_code), 32'd0);
        bus.in_valid = 1'b0;

        // Three known words, good checksum.
        words = '{10'h0A5, 10'h3FF, 10'h001};
        build(3, 8'h00, -1, 8'h00);
        run_frame(1'b0, 1'b0);

        // Bad lengths.
        build(0, 8'h00, -1, 8'h00);
        run_frame(1'b0, 1'b0);
        build(33, 8'h00, -1, 8'h00);
        run_frame(1'b0, 1'b0);

        // First HI byte out of range.
        rand_words(2);
        build(2, 8'h00, 0, 8'h04);
        run_frame(1'b0, 1'b0);

        // Checksum off by one.
        rand_words(2);
        build(2, 8'h01, -1, 8'h00);
        run_frame(1'b0, 1'b0);

        // Full-depth image with stream gaps and a stray start.
        rand_words(32);
        build(32, 8'h00, -1, 8'h00);
        run_frame(1'b1, 1'b1);

        // Reset while the second LO byte is on offer.
        rand_words(3);
        build(3, 8'h00, -1, 8'h00);
        wr_q.delete();
        pulse_start();
        for (int b = 0; b < 4; b++) send_byte(frame[b], 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = frame[4];
        reset        = 1'b1;
        @(negedge clock);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_mem_wren", 32'(bus.mem_wren), 32'd0);
        check("mid_rst_mem_address", 32'(bus.mem_address), 32'd0);
        check("mid_rst_mem_data", 32'(bus.mem_data), 32'd0);
        check("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err_code), 32'd0);
        repeat (3) @(negedge clock);
        check("mid_rst_writes", 32'(wr_q.size()), 32'd1);
        rand_words(1);
        build(1, 8'h00, -1, 8'h00);
        run_frame(1'b0, 1'b0);

        // Random frames, some corrupted.
        for (int k = 0; k < 8; k++) begin
            int len;
            int kind;
            len  = int'($urandom_range(1, 32));
            kind = int'($urandom_range(0, 3));
            rand_words(len);
            case (kind)
                1:       build(len, 8'($urandom_range(1, 255)), -1, 8'h00);
                2:       build(len, 8'h00, int'($urandom_range(0, len - 1)), 8'($urandom_range(4, 255)));
                3:       build(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 255)), 8'h00, -1, 8'h00);
                default: build(len, 8'h00, -1, 8'h00);
            endcase
            run_frame(1'b1, k[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
